// File: rtl/result_display.sv
// Captures RAM write-back results into a short history and scans a selected
// entry onto an 8-digit common-anode 7-segment display.
module result_display #(
  parameter int SCAN_DIV   = 50000,
  parameter int HIST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  sel,
  input  logic        hold,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [15:0] wr_count,
  output logic [31:0] latest,
  output logic [31:0] latest_addr
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(HIST_DEPTH + 1);

  logic [31:0]      hist_r [HIST_DEPTH];
  logic [31:0]      latest_addr_r;
  logic [CNT_W-1:0] valid_cnt_r;
  logic [15:0]      wr_count_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [2:0]       digit_r;
  logic [7:0]       seg_r;
  logic [7:0]       an_r;

  logic             capture_s;
  logic             disp_valid_s;
  logic [31:0]      disp_s;
  logic [3:0]       nibble_s;
  logic [7:0]       seg_next_s;
  logic [7:0]       an_next_s;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      4'hF:    hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  // hold blocks the strobe completely so the frozen view cannot drift
  assign capture_s    = wr_en & ~hold;
  assign disp_valid_s = {{(CNT_W-2){1'b0}}, sel} < valid_cnt_r;
  assign disp_s       = hist_r[sel];
  assign nibble_s     = disp_s[{digit_r, 2'b00} +: 4];

  // history shift register, write address and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_r[i] <= 32'h0000_0000;
      latest_addr_r <= 32'h0000_0000;
      valid_cnt_r   <= {CNT_W{1'b0}};
      wr_count_r    <= 16'h0000;
    end else if (capture_s) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) hist_r[i] <= hist_r[i-1];
      hist_r[0]     <= wr_data;
      latest_addr_r <= wr_addr;
      if (valid_cnt_r != CNT_W'(HIST_DEPTH)) valid_cnt_r <= valid_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (wr_count_r != 16'hFFFF) wr_count_r <= wr_count_r + 16'h0001;
    end
  end

  // next segment/anode pattern for the digit currently being scanned
  always_comb begin
    seg_next_s = 8'hFF;
    an_next_s  = ~(8'h01 << digit_r);
    if (disp_valid_s) begin
      seg_next_s[6:0] = hex7(nibble_s);
    end else begin
      seg_next_s[6:0] = 7'h7F;
    end
    if ((digit_r == 3'd0) && hold) begin
      seg_next_s[7] = 1'b0;
    end else begin
      seg_next_s[7] = 1'b1;
    end
  end

  // scan divider, digit index and registered display drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      digit_r   <= 3'd0;
      seg_r     <= 8'hFF;
      an_r      <= 8'hFF;
    end else begin
      seg_r <= seg_next_s;
      an_r  <= an_next_s;
      if (div_cnt_r == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt_r <= {DIV_W{1'b0}};
        digit_r   <= digit_r + 3'd1;
      end else begin
        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign seg         = seg_r;
  assign an          = an_r;
  assign wr_count    = wr_count_r;
  assign latest      = hist_r[0];
  assign latest_addr = latest_addr_r;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: scoreboard on the write-back outputs and
// a reference model of history/decode for the scanned display.
module tb_result_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic [1:0]  sel = 2'd0;
  logic        hold = 1'b0;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [15:0] wr_count;
  logic [31:0] latest;
  logic [31:0] latest_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [15:0] cnt;
  } wb_t;
  wb_t sb_q[$];

  logic [31:0] m_hist [4];
  int          m_valid;
  logic [15:0] m_count;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  result_display #(.SCAN_DIV(4), .HIST_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel), .hold(hold), .seg(seg), .an(an), .wr_count(wr_count),
    .latest(latest), .latest_addr(latest_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hist[i] = 32'h0;
    m_valid = 0;
    m_count = 16'h0;
  endtask

  task automatic model_write(input logic [31:0] d);
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = d;
    if (m_valid < 4) m_valid++;
    if (m_count != 16'hFFFF) m_count = m_count + 16'h1;
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    logic [31:0] v;
    logic [7:0]  r;
    r = 8'hFF;
    if (int'(sel) < m_valid) begin
      v = m_hist[sel];
      r[6:0] = seg_tab[v[4*d +: 4]];
    end
    if (d == 0 && hold) r[7] = 1'b0;
    return r;
  endfunction

  // Called at a negedge; leaves the bench at a negedge with rst released.
  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    sb_q.delete();
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // One strobe cycle; wr_en stays high so consecutive calls are back-to-back.
  task automatic strobe(input logic [31:0] a, input logic [31:0] d);
    wb_t e;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_write(d);
    e.data = m_hist[0]; e.addr = a; e.cnt = m_count;
    sb_q.push_back(e);
    @(posedge clk); @(negedge clk);
    if (sb_q.size() == 0) begin
      n_cmp++; n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      check("latest", latest, e.data);
      check("latest_addr", latest_addr, e.addr);
      check("wr_count", {16'h0, wr_count}, {16'h0, e.cnt});
    end
  endtask

  task automatic idle();
    wr_en = 1'b0;
  endtask

  // Waits until digit d has just become lit (bounded).
  task automatic wait_digit_start(input int d);
    logic [7:0] tgt;
    int n;
    tgt = ~(8'h01 << d);
    n = 0;
    do begin @(posedge clk); @(negedge clk); n++; end while (an === tgt && n < 80);
    do begin @(posedge clk); @(negedge clk); n++; end while (an !== tgt && n < 160);
    if (an !== tgt) begin
      n_cmp++; n_fail++;
      $error("FAIL scan_timeout: observed an=%h expected %h", an, tgt);
    end
  endtask

  task automatic check_digit(input int d, input string tag);
    wait_digit_start(d);
    check(tag, {24'h0, seg}, {24'h0, exp_seg(d)});
  endtask

  initial begin
    model_reset();
    // Reset state
    @(posedge clk); @(negedge clk);
    check("rst_an", {24'h0, an}, 32'hFF);
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_count", {16'h0, wr_count}, 32'h0);
    check("rst_latest", latest, 32'h0);
    check("rst_addr", latest_addr, 32'h0);

    // Scan sequence with no writes
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); @(negedge clk);
      check("scan_an", {24'h0, an}, {24'h0, ~(8'h01 << (((k - 1) / 4) % 8))});
      check("scan_seg", {24'h0, seg}, 32'hFF);
    end
    check("scan_count", {16'h0, wr_count}, 32'h0);

    // Single strobe
    sel = 2'd0;
    strobe(32'h5, 32'h0000_0008);
    idle();
    check_digit(0, "single_d0");
    check_digit(1, "single_d1");
    check_digit(7, "single_d7");

    // Five strobes, oldest shifted out
    do_reset();
    strobe(32'h10, 32'h1);
    strobe(32'h11, 32'h2);
    strobe(32'h12, 32'h3);
    strobe(32'h13, 32'h5);
    strobe(32'h14, 32'h8);
    idle();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      check_digit(0, "hist_sel_d0");
    end
    check_digit(1, "hist_sel3_d1");

    // Unfilled entry blank, then switch selection mid-digit
    do_reset();
    strobe(32'h20, 32'h1234_5678);
    strobe(32'h21, 32'h9ABC_DEF0);
    idle();
    sel = 2'd3;
    check_digit(5, "blank_d5");
    check_digit(0, "blank_d0");
    sel = 2'd1;
    @(posedge clk); @(negedge clk);
    check("switch_an", {24'h0, an}, 32'hFE);
    check("switch_seg", {24'h0, seg}, {24'h0, exp_seg(0)});

    // hold freezes history and lights dp on digit 0
    hold = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h99; wr_data = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    idle();
    check("hold_count", {16'h0, wr_count}, {16'h0, m_count});
    check("hold_latest", latest, m_hist[0]);
    check("hold_addr", latest_addr, 32'h21);
    check_digit(0, "hold_dp_d0");
    check_digit(1, "hold_dp_d1");
    hold = 1'b0;

    // Saturation of wr_count
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      wr_addr = i; wr_data = i;
      model_write(i);
      @(posedge clk); @(negedge clk);
    end
    check("sat_preload", {16'h0, wr_count}, 32'hFFFF);
    strobe(32'hABC, 32'hCAFE_F00D);
    idle();

    // Asynchronous reset mid-scan
    wait_digit_start(3);
    #1 rst = 1'b1;
    #1;
    check("arst_an", {24'h0, an}, 32'hFF);
    check("arst_seg", {24'h0, seg}, 32'hFF);
    check("arst_count", {16'h0, wr_count}, 32'h0);
    check("arst_latest", latest, 32'h0);
    check("arst_addr", latest_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Downstream consumer of the datapath's RAM write-back port (write strobe, address, data) during the iterative ALU computation.
- Captures each written 32-bit result into a small history buffer and counts the writes.
- Time-multiplexes a selected history entry onto an 8-digit common-anode 7-segment display, so the computed sequence can be inspected on the board.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit is driven before the scan advances. Must be at least 2. Use 4 in simulation.
- HIST_DEPTH, 4: number of history entries. Fixed at 4 in this revision; `sel` is 2 bits wide.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  RAM write strobe from control (wea). One capture per cycle in which it is high.
- wr_addr  in  32  RAM write address (addra). Captured alongside the data.
- wr_data  in  32  RAM write data (dina, the ALU result).
- sel  in  2  history index to display; 0 = newest.
- hold  in  1  1 = freeze history and counter; captures are ignored.
- seg  out  8  active-low segments. [6:0] = g..a, [7] = dp.
- an  out  8  active-low digit enables. an[0] = least significant hex digit.
- wr_count  out  16  number of accepted writes, saturating at 16'hFFFF.
- latest  out  32  newest captured data (hist[0]).
- latest_addr  out  32  address of the newest captured write.

Behaviour:
- Reset (asynchronous assert, synchronous release on next clk edge):
  - hist[0..3]=0, latest_addr=0, valid_cnt=0, wr_count=0.
  - div_cnt=0, digit=0.
  - seg=8'hFF, an=8'hFF (all dark).
- Capture: accepted on a rising edge when wr_en=1 and hold=0.
  - hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=wr_data, latest_addr<=wr_addr.
  - valid_cnt increments and saturates at 4.
  - wr_count increments and saturates at 16'hFFFF.
  - latest and wr_count update one cycle after the strobe.
  - With hold=1, wr_en is ignored entirely.
  - Back-to-back strobes on consecutive cycles are each captured; there is no lost write.
- Display value: disp = hist[sel] if sel < valid_cnt, otherwise "invalid".
  - Invalid digits show blank (segments 7'h7F).
- Scan:
  - div_cnt counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it wraps to 0 and digit advances (digit 7 wraps to 0).
  - seg/an are registered: an = ~(8'b1 << digit) and seg = decode(disp[4*digit+3 : 4*digit]), both sampled from the current digit and disp.
  - The first digit is lit on the first clk edge after reset release.
  - Changes to sel, or a capture, appear on the display at the next clk edge for the currently lit digit. The scan is not restarted.
- Decode, active-low g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Decimal point: seg[7]=0 only when digit==0 and hold==1; otherwise 1.
- Reset mid-scan or mid-capture: all state returns to the reset values immediately. A strobe coincident with reset release is dropped.
- Arithmetic: all counters are unsigned with no wrap except the digit index and div_cnt. wr_count holds at FFFF.

Test Plan:
- Reset, then release with no writes, SCAN_DIV=4 → an cycles FE, FD, FB … 7F, changing every 4 clocks. seg=FF on every digit; wr_count=0.
- Single strobe, wr_addr=5, wr_data=32'h0000_0008 → after 1 cycle: latest=8, latest_addr=5, wr_count=1. With sel=0: an=FE shows seg=00 ('8'), digits 1-7 show 40 ('0').
- Four back-to-back strobes with data 1, 2, 3, 5, then a fifth strobe with 8 → wr_count=5, valid_cnt=4. sel=0..3 shows 8, 5, 3, 2 respectively; the value 1 has been shifted out.
- After two writes, select an unfilled entry (sel=3) → all digits blank (seg=FF). Switch to sel=1 → digit 0 shows the older value on the next clock edge.
- hold=1 with a strobe of data DEAD_BEEF → history and wr_count unchanged. seg[7]=0 while an=FE; seg[7]=1 on the other digits.
- Preload 65535 writes, apply one more strobe → wr_count stays FFFF, latest updates. Assert rst mid-scan at a non-zero digit → an=FF and seg=FF immediately (asynchronously); all counters read 0.
